// File: rtl/edge_event_arbiter_if.sv
// Event handshake bundle between the edge event arbiter and its consumer.
//   evt_valid : event offered (arbiter -> consumer)
//   evt_ch    : channel index of the offered event (arbiter -> consumer)
//   evt_rise  : 1 rising edge, 0 falling edge (arbiter -> consumer)
//   evt_ready : consumer accepts the offered event (consumer -> arbiter)
// The master modport is the arbiter side and the slave modport is the consumer side.
interface edge_event_arbiter_if #(
  parameter int IDX_W = 2
);
  logic             evt_valid;
  logic [IDX_W-1:0] evt_ch;
  logic             evt_rise;
  logic             evt_ready;

  modport master (
    output evt_valid,
    output evt_ch,
    output evt_rise,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_ch,
    input  evt_rise,
    output evt_ready
  );
endinterface

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge event scheduler.
// Each asynchronous input line is synchronized, and its rising/falling edges are
// qualified by a per-channel mode. Qualified edges are held as one pending event
// per channel. Pending events are handed to a single consumer one at a time over a
// valid/ready handshake, with round-robin arbitration between channels.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   sig_in     : asynchronous input lines, one bit per channel
//   mode_cfg   : per-channel edge mode, bits [2i+1:2i]
//                (00 off, 01 rising, 10 falling, 11 both)
//   evt        : event handshake (master side): evt_valid/evt_ch/evt_rise out, evt_ready in
//   ovf_flag   : sticky per-channel flag, set when an edge was dropped
//   ovf_clr    : clears every ovf_flag bit (a new overflow in the same cycle wins)
//   evt_count  : number of accepted events, wraps modulo 2^CNT_W
module edge_event_arbiter #(
  parameter int N_CH  = 4,
  parameter int IDX_W = 2,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     sig_in,
  input  logic [2*N_CH-1:0]   mode_cfg,
  edge_event_arbiter_if.master evt,
  output logic [N_CH-1:0]     ovf_flag,
  input  logic                ovf_clr,
  output logic [CNT_W-1:0]    evt_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t state_reg;

  logic [N_CH-1:0]  s0_reg;
  logic [N_CH-1:0]  s1_reg;
  logic [N_CH-1:0]  s2_reg;
  logic [N_CH-1:0]  pend_reg;
  logic [N_CH-1:0]  pend_rise_reg;
  logic [N_CH-1:0]  ovf_reg;

  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  fall;
  logic [N_CH-1:0]  qual;
  logic [N_CH-1:0]  load;
  logic [N_CH-1:0]  ovf_set;

  logic             valid_reg;
  logic [IDX_W-1:0] ch_reg;
  logic             rise_out_reg;
  logic [IDX_W-1:0] last_grant_reg;
  logic [CNT_W-1:0] count_reg;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;

  // Per-channel synchronizer, edge qualification and pending/overflow state.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      always_ff @(posedge clk) begin
        if (rst) begin
          s0_reg[gi] <= 1'b0;
          s1_reg[gi] <= 1'b0;
          s2_reg[gi] <= 1'b0;
        end else begin
          s0_reg[gi] <= sig_in[gi];
          s1_reg[gi] <= s0_reg[gi];
          s2_reg[gi] <= s1_reg[gi];
        end
      end

      assign rise[gi] = s1_reg[gi] & ~s2_reg[gi];
      assign fall[gi] = ~s1_reg[gi] & s2_reg[gi];
      assign qual[gi] = (rise[gi] & mode_cfg[2*gi]) | (fall[gi] & mode_cfg[2*gi+1]);

      // The FSM takes this channel's pending event this cycle.
      assign load[gi] = (state_reg == IDLE) && pick_found && (pick_idx == IDX_W'(gi));

      // A channel being loaded frees its slot in the same cycle, so a new edge
      // arriving then is kept rather than counted as an overflow.
      assign ovf_set[gi] = qual[gi] & pend_reg[gi] & ~load[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          pend_reg[gi]      <= 1'b0;
          pend_rise_reg[gi] <= 1'b0;
          ovf_reg[gi]       <= 1'b0;
        end else begin
          if (qual[gi] && (!pend_reg[gi] || load[gi])) begin
            pend_reg[gi]      <= 1'b1;
            pend_rise_reg[gi] <= rise[gi];
          end else if (load[gi]) begin
            pend_reg[gi] <= 1'b0;
          end

          if (ovf_set[gi]) begin
            ovf_reg[gi] <= 1'b1;
          end else if (ovf_clr) begin
            ovf_reg[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  // Round-robin search starting just after the last granted channel, wrapping
  // explicitly so that channel counts that are not a power of two work too.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = last_grant_reg;
    for (int k = 0; k < N_CH; k++) begin
      cand = (cand == IDX_W'(N_CH - 1)) ? '0 : cand + 1'b1;
      if (!pick_found && pend_reg[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Delivery FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      valid_reg      <= 1'b0;
      ch_reg         <= '0;
      rise_out_reg   <= 1'b0;
      count_reg      <= '0;
      last_grant_reg <= IDX_W'(N_CH - 1);
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            ch_reg       <= pick_idx;
            rise_out_reg <= pend_rise_reg[pick_idx];
            valid_reg    <= 1'b1;
            state_reg    <= OFFER;
          end
        end
        OFFER: begin
          if (evt.evt_ready) begin
            valid_reg      <= 1'b0;
            count_reg      <= count_reg + 1'b1;
            last_grant_reg <= ch_reg;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign evt.evt_valid = valid_reg;
  assign evt.evt_ch    = ch_reg;
  assign evt.evt_rise  = rise_out_reg;
  assign ovf_flag      = ovf_reg;
  assign evt_count     = count_reg;

endmodule
